// File: rtl/calcu_pkg.sv
// Shared definitions for the guided-filter coefficient pipeline:
// FSM encoding, latency helpers and default image dimensions.
package calcu_pkg;

  localparam int IMG_W_DEF = 400;
  localparam int IMG_H_DEF = 300;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // One restoring stage per quotient bit of the widened numerator.
  function automatic int div_lat(input int data_w, input int frac);
    return data_w + frac;
  endfunction

  // Read address on iAddrA to its write on wrenB: RAM latency plus divider.
  function automatic int pipe_lat(input int data_w, input int frac);
    return 1 + div_lat(data_w, frac);
  endfunction

endpackage

// File: rtl/calcu_a_pipe_div_pipe.sv
// div_pipe: restoring pipelined divider, one quotient bit per stage,
// NUM_W stages deep, carrying a valid bit and an address tag alongside.
// A zero denominator yields a quotient of 0.
module div_pipe
  import calcu_pkg::*;
#(
  parameter int NUM_W = 31,
  parameter int DEN_W = 25,
  parameter int TAG_W = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [NUM_W-1:0] in_num,
  input  logic [DEN_W-1:0] in_den,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_vld,
  output logic [NUM_W-1:0] out_q,
  output logic [TAG_W-1:0] out_tag,
  output logic             pending
);

  // nq holds the not-yet-consumed numerator bits (high end) and the
  // quotient bits produced so far (low end) in a single shift register.
  logic             vld_r   [NUM_W];
  logic [NUM_W-1:0] nq_r    [NUM_W];
  logic [DEN_W-1:0] rem_r   [NUM_W];
  logic [DEN_W-1:0] den_r   [NUM_W];
  logic [TAG_W-1:0] tag_r   [NUM_W];

  logic             vld_src [NUM_W];
  logic [NUM_W-1:0] nq_src  [NUM_W];
  logic [DEN_W-1:0] rem_src [NUM_W];
  logic [DEN_W-1:0] den_src [NUM_W];
  logic [TAG_W-1:0] tag_src [NUM_W];

  logic [DEN_W:0]   trial   [NUM_W];
  logic [NUM_W-1:0] nq_nxt  [NUM_W];
  logic [DEN_W-1:0] rem_nxt [NUM_W];

  // Stage inputs: stage 0 takes the pipeline inputs, others the previous stage.
  always_comb begin
    vld_src[0] = in_vld;
    nq_src[0]  = in_num;
    rem_src[0] = '0;
    den_src[0] = in_den;
    tag_src[0] = in_tag;
    for (int s = 1; s < NUM_W; s++) begin
      vld_src[s] = vld_r[s-1];
      nq_src[s]  = nq_r[s-1];
      rem_src[s] = rem_r[s-1];
      den_src[s] = den_r[s-1];
      tag_src[s] = tag_r[s-1];
    end
  end

  // Restoring step: shift in the next numerator bit, subtract if it fits.
  always_comb begin
    for (int s = 0; s < NUM_W; s++) begin
      trial[s] = {rem_src[s], nq_src[s][NUM_W-1]};
      if (trial[s] >= {1'b0, den_src[s]}) begin
        rem_nxt[s] = DEN_W'(trial[s] - {1'b0, den_src[s]});
        nq_nxt[s]  = {nq_src[s][NUM_W-2:0], 1'b1};
      end else begin
        rem_nxt[s] = DEN_W'(trial[s]);
        nq_nxt[s]  = {nq_src[s][NUM_W-2:0], 1'b0};
      end
    end
  end

  // Stage registers; valid bits clear on reset so an aborted frame vanishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_W; s++) begin
        vld_r[s] <= 1'b0;
        nq_r[s]  <= '0;
        rem_r[s] <= '0;
        den_r[s] <= '0;
        tag_r[s] <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_W; s++) begin
        vld_r[s] <= vld_src[s];
        nq_r[s]  <= nq_nxt[s];
        rem_r[s] <= rem_nxt[s];
        den_r[s] <= den_src[s];
        tag_r[s] <= tag_src[s];
      end
    end
  end

  // Anything still in flight ahead of the output stage.
  always_comb begin
    pending = 1'b0;
    for (int s = 0; s < NUM_W - 1; s++) pending = pending | vld_r[s];
  end

  assign out_vld = vld_r[NUM_W-1];
  assign out_tag = tag_r[NUM_W-1];
  assign out_q   = (den_r[NUM_W-1] == '0) ? '0 : nq_r[NUM_W-1];

endmodule

// File: rtl/calcu_a_pipe.sv
// calcu_a_pipe: streams a variance plane from RAM A, computes
// a = (var << FRAC) / (var + eps) per pixel through a pipelined divider
// and writes it to RAM B at the same address, one pixel per clock.
// Build option CALCU_A_PIPE_EPS_PORT_EN adds a runtime iEps input that is
// latched at frame start; otherwise the EPS parameter is used.
//
// state | meaning
// IDLE  | waiting for ena, read counter at 0
// RUN   | issuing one read per cycle at address = counter
// DRAIN | no reads, waiting for the divider to empty
// DONE  | one-cycle done pulse
module calcu_a_pipe
  import calcu_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 24,
  parameter int OUT_W  = 24,
  parameter int FRAC   = 7,
  parameter int EPS    = 400
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              ena,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] oDataA,
  output logic              wrenA,
  output logic [ADDR_W-1:0] iAddrA,
  output logic              wrenB,
  output logic [ADDR_W-1:0] iAddrB,
  output logic [OUT_W-1:0]  iDataB
`ifdef CALCU_A_PIPE_EPS_PORT_EN
  ,
  input  logic [DATA_W-1:0] iEps
`endif
);

  localparam int N     = IMG_W * IMG_H;
  localparam int NUM_W = div_lat(DATA_W, FRAC);
  localparam int DEN_W = DATA_W + 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              last_rd;
  logic              rd_en;
  logic              vld_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] eps_cur;
  logic [NUM_W-1:0]  num;
  logic [DEN_W-1:0]  den;
  logic              div_vld;
  logic [NUM_W-1:0]  div_q;
  logic [ADDR_W-1:0] div_tag;
  logic              div_pending;

  assign last_rd = (cnt == ADDR_W'(N - 1));

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; ena only matters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ena) state_nxt = ST_RUN;
      ST_RUN:   if (last_rd) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!vld_a && !div_pending) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy   = (state != ST_IDLE);
    done   = (state == ST_DONE);
    rd_en  = (state == ST_RUN);
    iAddrA = rd_en ? cnt : '0;
  end

  // Read address counter, live only in RUN.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)            cnt <= '0;
    else if (rd_en && !last_rd) cnt <= cnt + ADDR_W'(1);
    else                    cnt <= '0;
  end

  // Delay read valid and address to line up with RAM A data.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vld_a  <= 1'b0;
      addr_a <= '0;
    end else begin
      vld_a  <= rd_en;
      addr_a <= iAddrA;
    end
  end

`ifdef CALCU_A_PIPE_EPS_PORT_EN
  logic [DATA_W-1:0] eps_r;

  // Epsilon is frozen for the whole frame at the IDLE->RUN transition.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)                      eps_r <= DATA_W'(EPS);
    else if (state == ST_IDLE && ena) eps_r <= iEps;
  end

  assign eps_cur = eps_r;
`else
  assign eps_cur = DATA_W'(EPS);
`endif

  assign num   = {oDataA, {FRAC{1'b0}}};
  assign den   = {1'b0, oDataA} + {1'b0, eps_cur};
  assign wrenA = 1'b0;

  div_pipe #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W),
    .TAG_W (ADDR_W)
  ) u_div (
    .clk     (iCLK),
    .rst_n   (iRST_N),
    .in_vld  (vld_a),
    .in_num  (num),
    .in_den  (den),
    .in_tag  (addr_a),
    .out_vld (div_vld),
    .out_q   (div_q),
    .out_tag (div_tag),
    .pending (div_pending)
  );

  // Quotient never exceeds 2^FRAC, so truncation to OUT_W is lossless.
  assign wrenB  = div_vld;
  assign iAddrB = div_vld ? div_tag : '0;
  assign iDataB = div_vld ? OUT_W'(div_q) : '0;

endmodule
